ads131_frame_capture: RTL
=========================

# ads131_frame_capture

- Receive-side stage directly downstream of the SPI master in the ADS131A0x interface.
- Deserializes the MISO bitstream of each CS-framed transaction into 24-bit words: one status word followed by NUM_CH channel words.
- Sign-extends channel words to 32 bits and buffers them in a small word FIFO with a valid/ready stream toward the NIOS II / DSP consumer.
- Detects truncated frames and FIFO overflow.

## Interface
Parameters:
- WORD_BITS, 24, bits per ADC word (16, 24 or 32)
- NUM_CH, 4, channel words per frame (1..4)
- FIFO_DEPTH, 8, word FIFO depth (power of two, ≥2)

Ports:
- synthesized_clock_4_167Mhz  in  1  block clock; reset reset_n is asynchronous, active-low
- reset_n  in  1  asynchronous active-low reset
- spi_cs  in  1  chip select from SPI master, active low, synchronous to clock
- miso_sample  in  1  one-cycle strobe: sample spi_miso this cycle (one strobe per SCLK bit)
- spi_miso  in  1  serial data, MSB first
- word_data  out  32  sign-extended word (status word zero-extended)
- word_index  out  3  0 = status, 1..NUM_CH = channel
- word_last  out  1  final word of frame
- word_valid  out  1  FIFO head valid
- word_ready  in  1  consumer accepts head when word_valid & word_ready
- frame_done  out  1  one-cycle pulse, complete frame captured
- frame_abort  out  1  one-cycle pulse, CS rose mid-frame
- overflow_cnt  out  8  saturating count of dropped words
- status_err  out  1  sticky: status word upper byte ≠ 0x22; cleared only by reset

## Operation
- States:
  - IDLE: spi_cs high; bit_cnt = 0, word_cnt = 0.
  - SHIFT: entered on spi_cs low. Each miso_sample shifts spi_miso into shift register LSB; bit_cnt increments.
  - DRAIN: after last frame word; further strobes ignored until CS high.
- IDLE→SHIFT on spi_cs = 0. SHIFT→DRAIN when the word completing is index NUM_CH (or CRC word, see Configuration). DRAIN→IDLE on spi_cs = 1.
- When bit_cnt reaches WORD_BITS:
  - The word is written to the FIFO with word_index = word_cnt and word_last = (word_cnt == NUM_CH).
  - bit_cnt resets to 0 and word_cnt increments.
- Channel words: bit WORD_BITS-1 is replicated into bits 31..WORD_BITS. Status word: upper bits are 0.
- Status check: status word bits [WORD_BITS-1 -: 8] must equal 0x22; any other value sets status_err.
- FIFO full at write time: word dropped, overflow_cnt += 1 (saturates at 255). Frame state continues.
- Simultaneous read and write while full: the read frees a slot and the write succeeds; no drop.
- SHIFT with spi_cs = 1 (truncated frame):
  - Partial word discarded; words already written remain.
  - frame_abort pulses; return to IDLE.
  - No word_last is emitted for that frame.
- miso_sample while spi_cs = 1: ignored.
- frame_done pulses on the SHIFT→DRAIN transition.

## Timing
- Reset values: word_data 0, word_index 0, word_last 0, word_valid 0, frame_done 0, frame_abort 0, overflow_cnt 0, status_err 0; FIFO empty; state IDLE.
- Latency: WORD_BITS-th strobe sampled at edge N → FIFO write at edge N+1 → word_valid high after edge N+1 (FIFO was empty).
- frame_done asserts after edge N+1 for the last word's strobe.
- frame_abort asserts the cycle after spi_cs is sampled high in SHIFT.
- Back-to-back strobes on consecutive cycles are supported.
- word_data, word_index and word_last hold stable while word_valid & !word_ready.
- Reset mid-frame: all state cleared immediately; FIFO contents lost.

## Configuration
- FRAME_CRC_EN defined:
  - Frame carries one extra word after channel NUM_CH.
  - Its upper 16 bits are compared with a CRC-CCITT (poly 0x1021, init 0xFFFF, MSB-first, bitwise serial) computed over all preceding frame bits.
  - The CRC word is not written to the FIFO.
  - Adds output crc_err (one-cycle pulse with frame_done on mismatch) and crc_err_cnt (8-bit saturating).
  - SHIFT→DRAIN occurs after the CRC word.
  - word_last remains on channel word NUM_CH.
- FRAME_CRC_EN undefined: frame is 1+NUM_CH words; no CRC logic or ports.

## Test plan
- Full frame, word_ready = 1: status 0x220000, channels 0x7FFFFF, 0x800000, 0x000001, 0xFFFFFF → words 0x00220000, 0x007FFFFF, 0xFF800000, 0x00000001, 0xFFFFFFFF with indices 0..4, word_last on index 4, one frame_done, status_err = 0.
- Status 0x210000 → status_err sets and stays set across following good frames until reset_n pulse.
- word_ready = 0 across two frames (10 words, FIFO_DEPTH 8) → 8 words retained, overflow_cnt = 2, then drained in order.
- CS rises after 2 words + 11 bits → 2 words in FIFO, frame_abort pulse, no word_last; next frame captured correctly.
- reset_n low during SHIFT of word 3 → all outputs at reset values, next frame starts at index 0.
- FRAME_CRC_EN: correct CRC → crc_err stays 0. Flip one channel bit → crc_err pulse, crc_err_cnt = 1, 5 data words still delivered.

Source files
------------

// File: rtl/ads131_frame_capture.sv
// ads131_frame_capture: deserializes CS-framed ADS131A0x MISO data into sign-extended words
// buffered in a valid/ready word FIFO; flags truncated frames, FIFO drops and bad status.
// Optional build macro FRAME_CRC_EN: a trailing CRC-CCITT word is checked (crc_err, crc_err_cnt).
module ads131_frame_capture #(
    parameter int WORD_BITS  = 24,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        synthesized_clock_4_167Mhz,
    input  logic        reset_n,
    input  logic        spi_cs,
    input  logic        miso_sample,
    input  logic        spi_miso,
    output logic [31:0] word_data,
    output logic [2:0]  word_index,
    output logic        word_last,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [7:0]  overflow_cnt,
`ifdef FRAME_CRC_EN
    output logic        crc_err,
    output logic [7:0]  crc_err_cnt,
`endif
    output logic        status_err
);
    localparam int BW = $clog2(WORD_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] LAST_IDX = 3'(NUM_CH);
`ifdef FRAME_CRC_EN
    localparam logic [2:0] FINAL_IDX = 3'(NUM_CH + 1);
`else
    localparam logic [2:0] FINAL_IDX = 3'(NUM_CH);
`endif
    localparam logic [63:0] LOW_MASK = (64'd1 << WORD_BITS) - 64'd1;
    localparam logic [31:0] UPPER = ~LOW_MASK[31:0];

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;
    state_t r_state, w_next_state;

    logic [WORD_BITS-2:0] r_shift;
    logic [BW-1:0]        r_bit_cnt;
    logic [2:0]           r_word_cnt;
    logic                 r_wr_v, r_wr_last, r_fin, r_done, r_abort, r_serr;
    logic [WORD_BITS-1:0] r_wr_data;
    logic [2:0]           r_wr_idx;
    logic [7:0]           r_ovf;
    logic                 w_shift_en, w_word_done, w_frame_end, w_abort;
    logic [WORD_BITS-1:0] w_word;

    logic [35:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic [AW:0] w_count;
    logic        w_full, w_rd, w_wr;
    logic [35:0] w_head, w_fifo_in;

    assign w_word = {r_shift, spi_miso};

    // state register
    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n)
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;

    // next state and per-cycle strobe decode; strobes count only once SHIFT is entered
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_word_done  = 1'b0;
        w_frame_end  = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE:  if (!spi_cs) w_next_state = SHIFT;
            SHIFT: begin
                if (spi_cs) begin
                    w_next_state = IDLE;
                    w_abort      = 1'b1;
                end else if (miso_sample) begin
                    w_shift_en  = 1'b1;
                    w_word_done = (r_bit_cnt == BW'(WORD_BITS - 1));
                    w_frame_end = w_word_done && (r_word_cnt == FINAL_IDX);
                    if (w_frame_end) w_next_state = DRAIN;
                end
            end
            DRAIN: if (spi_cs) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // deserializer: completed words are staged one cycle before the FIFO write
    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n)
        if (!reset_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_wr_v     <= 1'b0;
            r_wr_data  <= '0;
            r_wr_idx   <= '0;
            r_wr_last  <= 1'b0;
            r_fin      <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_wr_v  <= 1'b0;
            r_fin   <= w_frame_end;
            r_done  <= r_fin;
            r_abort <= w_abort;
            if (r_state != SHIFT) begin
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= w_word[WORD_BITS-2:0];
                r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + 1'b1;
                if (w_word_done) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_wr_v     <= (r_word_cnt <= LAST_IDX);
                    r_wr_data  <= w_word;
                    r_wr_idx   <= r_word_cnt;
                    r_wr_last  <= (r_word_cnt == LAST_IDX);
                end
            end
        end

    assign w_count   = r_wp - r_rp;
    assign w_full    = (w_count == (AW + 1)'(FIFO_DEPTH));
    assign word_valid = (r_wp != r_rp);
    assign w_rd      = word_valid & word_ready;
    assign w_wr      = r_wr_v & (!w_full | w_rd);
    assign w_fifo_in = {r_wr_idx, r_wr_last,
                        32'(r_wr_data) | ((r_wr_idx != 3'd0 && r_wr_data[WORD_BITS-1]) ? UPPER : 32'd0)};
    assign w_head    = r_mem[r_rp[AW-1:0]];
    assign word_data  = word_valid ? w_head[31:0] : 32'd0;
    assign word_last  = word_valid & w_head[32];
    assign word_index = word_valid ? w_head[35:33] : 3'd0;

    // FIFO storage
    always_ff @(posedge synthesized_clock_4_167Mhz)
        if (w_wr) r_mem[r_wp[AW-1:0]] <= w_fifo_in;

    // FIFO pointers, drop counter and sticky status check
    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n)
        if (!reset_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_ovf  <= '0;
            r_serr <= 1'b0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            if (r_wr_v && !w_wr && r_ovf != 8'hFF) r_ovf <= r_ovf + 1'b1;
            if (r_wr_v && r_wr_idx == 3'd0 && r_wr_data[WORD_BITS-1 -: 8] != 8'h22) r_serr <= 1'b1;
        end

    assign frame_done   = r_done;
    assign frame_abort  = r_abort;
    assign overflow_cnt = r_ovf;
    assign status_err   = r_serr;

`ifdef FRAME_CRC_EN
    logic [15:0] r_crc, w_crc_next;
    logic        r_crc_bad, r_crc_err;
    logic [7:0]  r_crc_cnt;

    assign w_crc_next = {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ spi_miso) ? 16'h1021 : 16'h0000);

    // serial CRC over status and channel bits, compared against the CRC word's upper 16 bits
    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n)
        if (!reset_n) begin
            r_crc     <= 16'hFFFF;
            r_crc_bad <= 1'b0;
            r_crc_err <= 1'b0;
            r_crc_cnt <= '0;
        end else begin
            r_crc_bad <= (w_word[WORD_BITS-1 -: 16] != r_crc);
            r_crc_err <= r_fin & r_crc_bad;
            if (r_fin && r_crc_bad && r_crc_cnt != 8'hFF) r_crc_cnt <= r_crc_cnt + 1'b1;
            if (r_state != SHIFT) r_crc <= 16'hFFFF;
            else if (w_shift_en && r_word_cnt <= LAST_IDX) r_crc <= w_crc_next;
        end

    assign crc_err     = r_crc_err;
    assign crc_err_cnt = r_crc_cnt;
`endif
endmodule
